// File: rtl/lisnoc_router_output_alloc_pkg.sv
// Shared flit-type codes, allocator FSM states and helpers
// for the router output allocator slice.
package lisnoc_router_output_alloc_pkg;

   localparam logic [1:0] FLIT_TYPE_PAYLOAD = 2'b00;
   localparam logic [1:0] FLIT_TYPE_HEADER  = 2'b01;
   localparam logic [1:0] FLIT_TYPE_LAST    = 2'b10;
   localparam logic [1:0] FLIT_TYPE_SINGLE  = 2'b11;

   localparam logic [0:0] ST_IDLE   = 1'b0;
   localparam logic [0:0] ST_LOCKED = 1'b1;

   // Index width for a port count, never below one bit.
   function automatic int idx_width(input int n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

   // True when a flit terminates a wormhole packet.
   function automatic logic flit_closes(input logic [1:0] t);
      logic c;
      c = 1'b0;
      case (t)
         FLIT_TYPE_HEADER:  c = 1'b0;
         FLIT_TYPE_PAYLOAD: c = 1'b0;
         FLIT_TYPE_LAST:    c = 1'b1;
         FLIT_TYPE_SINGLE:  c = 1'b1;
         default:           c = 1'b0;
      endcase
      return c;
   endfunction

   // True when a flit opens a packet that must hold the lock.
   function automatic logic flit_opens(input logic [1:0] t);
      return t == FLIT_TYPE_HEADER;
   endfunction

endpackage

// File: rtl/lisnoc_arb_rr.sv
// Combinational round-robin arbiter: searches upward from the
// port after last_grant, wrapping at ports-1 back to 0.
module lisnoc_arb_rr
   import lisnoc_router_output_alloc_pkg::*;
#(
   parameter int ports = 5,
   parameter int idx_w = idx_width(ports)
) (
   input  logic [ports-1:0] req,
   input  logic [idx_w-1:0] last_grant,
   output logic [ports-1:0] gnt,
   output logic [idx_w-1:0] idx
);

   localparam logic [idx_w-1:0] LAST_IDX = idx_w'(ports - 1);

   // Walk all ports once, starting after last_grant; first hit wins.
   always_comb begin
      logic [idx_w-1:0] cand;
      logic             found;
      gnt   = '0;
      idx   = '0;
      found = 1'b0;
      cand  = last_grant;
      for (int k = 0; k < ports; k++) begin
         if (cand == LAST_IDX)
            cand = '0;
         else
            cand = cand + 1'b1;
         if (!found && req[cand]) begin
            found = 1'b1;
            idx   = cand;
         end
      end
      if (found)
         gnt[idx] = 1'b1;
   end

endmodule

// File: rtl/lisnoc_router_output_alloc.sv
// Output-port switch allocator: round-robin grant, wormhole lock
// from header to last flit, one-entry registered output stage.
module lisnoc_router_output_alloc
   import lisnoc_router_output_alloc_pkg::*;
#(
   parameter int flit_data_width = 32,
   parameter int flit_type_width = 2,
   parameter int ports           = 5
) (
   input  logic                                      clk,
   input  logic                                      rst,
   input  logic [ports-1:0]                          switch_request,
   input  logic [(flit_data_width+flit_type_width)*ports-1:0] switch_flit,
   output logic [ports-1:0]                          switch_read,
   output logic [flit_data_width+flit_type_width-1:0] out_flit,
   output logic                                      out_valid,
   input  logic                                      out_ready
);

   localparam int flit_width = flit_data_width + flit_type_width;
   localparam int idx_w      = idx_width(ports);
   localparam logic [idx_w-1:0] LAST_IDX = idx_w'(ports - 1);

   logic [0:0]             state;
   logic [idx_w-1:0]       owner;
   logic [idx_w-1:0]       last_grant;

   logic [ports-1:0]       arb_gnt;
   logic [idx_w-1:0]       arb_idx;
   logic                   can_accept;
   logic                   read_fire;
   logic [idx_w-1:0]       sel_idx;
   logic [flit_width-1:0]  sel_flit;
   logic [flit_type_width-1:0] sel_type;
   logic [1:0]             sel_kind;

   lisnoc_arb_rr #(
      .ports (ports),
      .idx_w (idx_w)
   ) u_arb (
      .req        (switch_request),
      .last_grant (last_grant),
      .gnt        (arb_gnt),
      .idx        (arb_idx)
   );

   assign can_accept = !out_valid || out_ready;

   // Select the flit of the port that is (or would be) read.
   always_comb begin
      sel_idx  = (state == ST_LOCKED) ? owner : arb_idx;
      sel_flit = switch_flit[int'(sel_idx)*flit_width +: flit_width];
      sel_type = sel_flit[flit_width-1 -: flit_type_width];
      sel_kind = 2'(sel_type);
   end

   // Read strobe: arbiter winner when idle, only the owner when locked.
   always_comb begin
      switch_read = '0;
      if (!rst && can_accept) begin
         case (state)
            ST_IDLE:   switch_read = arb_gnt;
            ST_LOCKED: switch_read[owner] = switch_request[owner];
            default:   switch_read = '0;
         endcase
      end
   end

   assign read_fire = |switch_read;

   // Output register: reload on read, drain on downstream accept.
   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid <= 1'b0;
         out_flit  <= '0;
      end else if (read_fire) begin
         out_valid <= 1'b1;
         out_flit  <= sel_flit;
      end else if (out_ready) begin
         out_valid <= 1'b0;
      end
   end

   // Lock FSM and round-robin pointer.
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= ST_IDLE;
         owner      <= '0;
         last_grant <= LAST_IDX;
      end else if (read_fire) begin
         case (state)
            ST_IDLE: begin
               last_grant <= arb_idx;
               if (flit_opens(sel_kind)) begin
                  state <= ST_LOCKED;
                  owner <= arb_idx;
               end
            end
            ST_LOCKED: begin
               if (flit_closes(sel_kind))
                  state <= ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule
